// File: rtl/half_adder_checker.sv
// -----------------------------------------------------------------------------
// half_adder_checker
//
// Response checker for a half adder. Observations {a, b, sum, carry} arrive over
// a valid/ready handshake and each one is compared against sum = a ^ b and
// carry = a & b. A run checks NUM_VECTORS observations. During the run the
// checker counts vectors and mismatches and captures the first failing vector.
// At the end it reports a pass/fail verdict.
//
// Handshake: a transfer happens on a rising edge where valid_in and ready_out are
// both 1. ready_out is 1 only in RUN. valid_in is ignored while ready_out is 0,
// so those observations are neither counted nor checked. The producer does not
// have to hold data while ready_out is 0.
//
// Ports
//   clk_in              clock, rising edge
//   rst_in              asynchronous, active-high reset
//   start_in            begin a run (sampled in IDLE and DONE only)
//   valid_in            observation on a_in/b_in/sum_in/carry_in is valid
//   a_in, b_in          DUT operands
//   sum_in, carry_in    DUT results
//   ready_out           checker accepts an observation this cycle
//   busy_out            run in progress
//   done_out            run complete; held until next start or reset
//   pass_out            verdict while done_out=1; 1 iff no mismatches
//   mismatch_out        one-cycle pulse after a failing vector is accepted
//   vec_count_out       vectors accepted this run
//   err_count_out       mismatches this run, saturating
//   first_fail_idx_out  0-based index of the first failing vector
//   first_fail_vec_out  {a, b, sum, carry} of the first failing vector
// -----------------------------------------------------------------------------
module half_adder_checker #(
    parameter int NUM_VECTORS = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             valid_in,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             sum_in,
    input  logic             carry_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             pass_out,
    output logic             mismatch_out,
    output logic [CNT_W-1:0] vec_count_out,
    output logic [CNT_W-1:0] err_count_out,
    output logic [CNT_W-1:0] first_fail_idx_out,
    output logic [3:0]       first_fail_vec_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The state register can be probed by name when binding checkers.
    state_t state;
    state_t state_nxt;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic start_run;   // start sampled in IDLE/DONE: clear and enter RUN
    logic xfer;        // an observation is accepted on this edge
    logic last_xfer;   // the accepted observation is the final one of the run
    logic vec_bad;     // the observation disagrees with a half adder
    logic ff_flag;     // first failure already captured this run

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        xfer      = 1'b0;
        last_xfer = 1'b0;
        vec_bad   = (sum_in != (a_in ^ b_in)) || (carry_in != (a_in & b_in));

        case (state)
            IDLE, DONE: begin
                if (start_in) begin
                    start_run = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // start_in is deliberately not looked at here.
                if (valid_in && ready_out) begin
                    xfer = 1'b1;
                    // The count before the increment equals NUM_VECTORS-1
                    // exactly when this transfer completes the run.
                    if (vec_count_out == LAST_IDX) begin
                        last_xfer = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and run bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ready_out          <= 1'b0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            pass_out           <= 1'b0;
            mismatch_out       <= 1'b0;
            vec_count_out      <= '0;
            err_count_out      <= '0;
            first_fail_idx_out <= '0;
            first_fail_vec_out <= '0;
            ff_flag            <= 1'b0;
        end else begin
            // Status flags are decoded from the next state. That way they
            // change on the same edge as the state and need no drain cycle.
            ready_out    <= (state_nxt == RUN);
            busy_out     <= (state_nxt == RUN);
            done_out     <= (state_nxt == DONE);
            mismatch_out <= 1'b0;

            if (start_run) begin
                pass_out           <= 1'b0;
                vec_count_out      <= '0;
                err_count_out      <= '0;
                first_fail_idx_out <= '0;
                first_fail_vec_out <= '0;
                ff_flag            <= 1'b0;
            end else if (xfer) begin
                vec_count_out <= vec_count_out + 1'b1;
                if (vec_bad) begin
                    mismatch_out <= 1'b1;
                    if (err_count_out != CNT_MAX) begin
                        err_count_out <= err_count_out + 1'b1;
                    end
                    if (!ff_flag) begin
                        ff_flag            <= 1'b1;
                        first_fail_idx_out <= vec_count_out;
                        first_fail_vec_out <= {a_in, b_in, sum_in, carry_in};
                    end
                end
                // The verdict must include the last vector, whose error has
                // not reached err_count_out yet.
                if (last_xfer) begin
                    pass_out <= (err_count_out == '0) && !vec_bad;
                end
            end
        end
    end

endmodule

// File: doc/half_adder_checker.md
# half_adder_checker

Synthesizable response checker for the half adder: the receiving end of the stimulus a half-adder bench drives. It accepts a stream of {a, b, sum, carry} observations over a valid/ready handshake and compares each against the expected result (sum = a^b, carry = a&b). It counts vectors and mismatches, captures the first failing vector, and reports a pass/fail verdict once a programmed number of vectors has been checked. It sits beside the half adder DUT in self-checking benches and in on-board BIST wrappers.

## Interface
- NUM_VECTORS, 8, number of vectors checked per run; legal range 1 .. 2^CNT_W-1.
- CNT_W, 8, width of all counters and indices.

- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  begin a run; sampled in IDLE and DONE only.
- valid_in  input  1  observation on a_in/b_in/sum_in/carry_in is valid.
- a_in  input  1  DUT operand a.
- b_in  input  1  DUT operand b.
- sum_in  input  1  DUT sum output.
- carry_in  input  1  DUT carry output.
- ready_out  output  1  checker accepts an observation this cycle.
- busy_out  output  1  run in progress.
- done_out  output  1  run complete; level, held until next start or reset.
- pass_out  output  1  valid when done_out=1; 1 iff zero mismatches.
- mismatch_out  output  1  one-cycle pulse, the cycle after a failing vector is accepted.
- vec_count_out  output  CNT_W  vectors accepted this run.
- err_count_out  output  CNT_W  mismatches this run; saturates at all-ones.
- first_fail_idx_out  output  CNT_W  index (0-based) of the first failing vector.
- first_fail_vec_out  output  4  {a, b, sum, carry} of the first failing vector.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start_in=1. The transition clears vec_count, err_count, first_fail_idx, first_fail_vec and the internal first-fail flag.
- RUN: ready_out=1, busy_out=1. A transfer occurs on a cycle with valid_in=1 and ready_out=1.
- On each transfer:
  - vec_count increments.
  - The vector mismatches if sum_in != (a_in^b_in) or carry_in != (a_in&b_in).
  - On a mismatch, err_count increments, saturating at 2^CNT_W-1, and mismatch_out pulses.
  - On the first mismatch of the run, the first-fail flag is set and {a_in, b_in, sum_in, carry_in} and the current vec_count (pre-increment) are captured. Later mismatches leave the capture unchanged.
- RUN -> DONE on the transfer that makes vec_count equal NUM_VECTORS. That last vector is still checked and counted.
- start_in in RUN is ignored.
- DONE: ready_out=0, busy_out=0, done_out=1. pass_out = (err_count == 0). Counters hold.
- DONE -> RUN on start_in=1, with the same clears as IDLE -> RUN. There is no path back to IDLE except reset.
- valid_in while ready_out=0 is dropped: not counted, not checked.
- When no first failure has been captured, first_fail_idx_out and first_fail_vec_out read 0.

## Timing
- Every output is registered. Reset values: all outputs 0, FSM in IDLE.
- ready_out and busy_out rise the cycle after start_in is sampled.
- A vector accepted on edge N updates vec_count_out, err_count_out, the first-fail outputs and mismatch_out after edge N; they are visible in cycle N+1.
- The final transfer on edge N gives done_out=1, pass_out valid, ready_out=0 in cycle N+1. There is no extra drain cycle.
- Back-to-back transfers are sustained at one per cycle; there are no bubbles inside a run.
- Reset asserted mid-run: outputs clear immediately (asynchronous) and the FSM returns to IDLE. The partial run is discarded.
- start_in held high continuously: it starts a run from IDLE, is ignored during RUN, and restarts the cycle after DONE is entered. done_out is high for exactly one cycle in that case.

## Test plan
- Reset, then start, then the 4 correct vectors {00/00, 01/10, 10/10, 11/01} twice with NUM_VECTORS=8 -> vec_count_out=8, err_count_out=0, done_out=1 and pass_out=1 in the cycle after the 8th transfer, mismatch_out never high.
- Run with vector 3 = a=1, b=1, sum=1, carry=1 and vector 6 = a=0, b=1, sum=0, carry=0 -> err_count_out=2, first_fail_idx_out=3, first_fail_vec_out=4'b1111, pass_out=0, mismatch_out pulsed twice.
- valid_in toggling every other cycle, plus valid_in=1 in IDLE and DONE -> only RUN transfers counted; vec_count_out=8 exactly; the IDLE/DONE inputs are ignored.
- Reset asserted asynchronously after 5 vectors (between clock edges) -> all outputs 0 immediately; a new start and 8 clean vectors gives pass_out=1.
- CNT_W=2, NUM_VECTORS=3, all 3 vectors wrong -> err_count_out=3 (saturation boundary), first_fail_idx_out=0, pass_out=0.
- start_in held high across DONE -> new run begins one cycle after done_out rises, with counters cleared to 0.
